// File: rtl/iob_gpio_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : iob_gpio_input_cond
// Brief    : GPIO pad input conditioner. Two-flop synchroniser, per-bit
//            debounce with edge pulses, windowed rising-edge event counter.
// Revision : 1.0  initial release
// ============================================================================
module iob_gpio_input_cond #(
  parameter int GPIO_W = 32,
  parameter int DEB_W  = 8,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_raw_i,
  input  logic [DEB_W-1:0]  deb_len_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  win_len_i,
  input  logic [SEL_W-1:0]  evt_sel_i,
  output logic [GPIO_W-1:0] gpio_clean_o,
  output logic [GPIO_W-1:0] gpio_rise_o,
  output logic [GPIO_W-1:0] gpio_fall_o,
  output logic [CNT_W-1:0]  evt_count_o,
  output logic              evt_ovf_o,
  output logic              evt_valid_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [GPIO_W-1:0] clean_vec;
  logic [GPIO_W-1:0] rise_vec;
  logic [GPIO_W-1:0] fall_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_raw_i;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar g = 0; g < GPIO_W; g++) begin : g_deb
      logic [DEB_W-1:0] cnt_q;
      logic [DEB_W-1:0] cnt_d;
      logic             clean_q;
      logic             clean_d;
      logic             rise_q;
      logic             rise_d;
      logic             fall_q;
      logic             fall_d;

      // >= rather than == so a lowered deb_len mid-count accepts promptly
      // instead of letting the counter wrap.
      always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q[g] == clean_q) begin
          cnt_d = '0;
        end else if (cnt_q >= deb_len_i) begin
          cnt_d   = '0;
          clean_d = sync2_q[g];
          rise_d  = sync2_q[g];
          fall_d  = ~sync2_q[g];
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q   <= '0;
          clean_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          clean_q <= clean_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign clean_vec[g] = clean_q;
      assign rise_vec[g]  = rise_q;
      assign fall_vec[g]  = fall_q;
    end
  endgenerate

  // Out-of-range selects never match any channel, so they count nothing.
  logic sel_rise;
  always_comb begin
    sel_rise = 1'b0;
    for (int i = 0; i < GPIO_W; i++) begin
      if (evt_sel_i == SEL_W'(i)) sel_rise = rise_vec[i];
    end
  end

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] win_d;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic             ovf_acc_q;
  logic             ovf_acc_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             valid_q;
  logic             valid_d;

  logic             acc_full;
  logic             sat_now;
  logic [CNT_W-1:0] acc_sum;
  logic             win_run;
  logic             win_last;

  assign acc_full = &acc_q;
  assign sat_now  = acc_full & sel_rise;
  assign acc_sum  = acc_full ? acc_q : acc_q + CNT_W'(sel_rise);
  assign win_run  = en_i && (win_len_i != '0);
  assign win_last = (win_q == win_len_i - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_run)  state_d = COUNT;
      COUNT:   if (!win_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_d     = win_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      COUNT: begin
        if (!win_run) begin
          win_d     = '0;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (win_last) begin
          // Publish and restart in the same cycle: windows abut with no gap.
          count_d   = acc_sum;
          ovf_d     = ovf_acc_q | sat_now;
          valid_d   = 1'b1;
          win_d     = '0;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end else begin
          win_d     = win_q + CNT_W'(1);
          acc_d     = acc_sum;
          ovf_acc_d = ovf_acc_q | sat_now;
        end
      end
      default: begin
        win_d     = '0;
        acc_d     = '0;
        ovf_acc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      win_q     <= win_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign gpio_clean_o = clean_vec;
  assign gpio_rise_o  = rise_vec;
  assign gpio_fall_o  = fall_vec;
  assign evt_count_o  = count_q;
  assign evt_ovf_o    = ovf_q;
  assign evt_valid_o  = valid_q;

endmodule
`default_nettype wire
